// File: rtl/hxd32_ifu_pkg.sv
// Shared types and constants for the hxd32 prefetching fetch unit.
// Contents:
//   IFU_XLEN     - word width that the buffered entry type is built for
//   ILEN_BYTES   - size of one instruction in bytes (PC step)
//   ifu_state_t  - fetch control states (BOOT, RUN, HALT)
//   ifu_entry_t  - one buffered instruction together with its PC
package hxd32_ifu_pkg;

  localparam int IFU_XLEN   = 32;
  localparam int ILEN_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } ifu_state_t;

  typedef struct packed {
    logic [IFU_XLEN-1:0] pc;
    logic [IFU_XLEN-1:0] inst;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch buffer: synchronous FIFO of ifu_entry_t with first-word-fall-through head.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   flush               - drop every buffered entry (takes priority over push/pop)
//   push, push_entry    - write one entry at the tail
//   pop                 - remove the head entry (caller only pops when head_valid)
//   head_valid          - buffer holds at least one entry
//   head_entry          - current head, read combinationally from storage
//   count               - number of buffered entries (0..DEPTH)
module ifu_fifo
  import hxd32_ifu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  ifu_entry_t             push_entry,
  input  logic                   pop,
  output logic                   head_valid,
  output ifu_entry_t             head_entry,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ifu_entry_t      mem_reg [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   count_next;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_reg[wr_ptr_reg] <= push_entry;
    end
  end

  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else begin
      count_next = count_reg + CW'(push) - CW'(pop);
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

  assign head_valid = (count_reg != '0);
  assign head_entry = mem_reg[rd_ptr_reg];
  assign count      = count_reg;

endmodule

// File: rtl/ifu_pf.sv
// Prefetching instruction fetch unit for the hxd32 core.
// Keeps a fetch PC, issues in-order reads to instruction RAM (valid/grant),
// buffers up to DEPTH returned words with their PCs and hands them to decode
// over valid/ready. Redirects flush the buffer and discard in-flight reads.
// Ports:
//   clk_i, rst_i            - clock, asynchronous active-high reset
//   halt_i                  - stop issuing new requests (buffer still drains)
//   redirect_en_i/addr_i    - restart the fetch stream at addr & ~3
//   iram_rd_req_o/addr_o    - read request and its address (fetch PC)
//   iram_rd_gnt_i           - request accepted this cycle
//   iram_rd_valid_i/data_i  - in-order read response
//   inst_valid_o/ready_i    - decode handshake on the buffer head
//   inst_data_o, pc_data_o, pc_next_o - head word, its PC and PC + 4 (0 when idle)
// XLEN must equal IFU_XLEN from hxd32_ifu_pkg.
module ifu_pf
  import hxd32_ifu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            halt_i,
  input  logic            redirect_en_i,
  input  logic [XLEN-1:0] redirect_addr_i,
  output logic            iram_rd_req_o,
  output logic [XLEN-1:0] iram_rd_addr_o,
  input  logic            iram_rd_gnt_i,
  input  logic            iram_rd_valid_i,
  input  logic [XLEN-1:0] iram_rd_data_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] inst_data_o,
  output logic [XLEN-1:0] pc_data_o,
  output logic [XLEN-1:0] pc_next_o
);

  localparam int              CW         = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(ILEN_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(ILEN_BYTES - 1);

  ifu_state_t      state_reg;
  ifu_state_t      state_next;
  logic [XLEN-1:0] fetch_pc_reg;
  logic [XLEN-1:0] resp_pc_reg;
  logic [CW-1:0]   outstanding_reg;
  logic [CW-1:0]   outstanding_next;
  logic [CW-1:0]   drop_reg;
  logic [CW-1:0]   drop_next;

  logic            redirect;
  logic            credit_ok;
  logic            req;
  logic            issue;
  logic            resp;
  logic            accept;
  logic            pop;
  logic [XLEN-1:0] redirect_pc;

  logic            fifo_valid;
  logic [CW-1:0]   fifo_count;
  ifu_entry_t      fifo_head;
  ifu_entry_t      push_entry;

  // Redirects are ignored during the single BOOT cycle.
  assign redirect    = redirect_en_i && (state_reg != BOOT);
  assign redirect_pc = redirect_addr_i & ALIGN_MASK;

  // Buffered plus in-flight words may never exceed DEPTH, so every response
  // is guaranteed a free buffer slot.
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding_reg}) < (CW + 1)'(DEPTH);

  always_comb begin
    state_next = state_reg;
    req        = 1'b0;
    case (state_reg)
      BOOT: state_next = RUN;
      RUN: begin
        req = !redirect_en_i && credit_ok;
        if (halt_i) state_next = HALT;
      end
      HALT: begin
        if (!halt_i) state_next = RUN;
      end
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= BOOT;
    else       state_reg <= state_next;
  end

  assign issue = req && iram_rd_gnt_i;
  // A response with nothing outstanding is a protocol error; it is ignored
  // rather than allowed to underflow the counter.
  assign resp   = iram_rd_valid_i && (outstanding_reg != '0);
  assign accept = resp && !redirect && (drop_reg == '0);

  assign inst_valid_o = fifo_valid && !redirect;
  assign pop          = inst_valid_o && inst_ready_i;

  always_comb begin
    outstanding_next = outstanding_reg + CW'(issue) - CW'(resp);
    drop_next        = drop_reg;
    if (redirect) begin
      // Everything still in flight after this cycle belongs to the old stream.
      drop_next = outstanding_next;
    end else if (resp && (drop_reg != '0)) begin
      drop_next = drop_reg - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      drop_reg        <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
      drop_reg        <= drop_next;
      if (redirect) begin
        fetch_pc_reg <= redirect_pc;
        resp_pc_reg  <= redirect_pc;
      end else begin
        if (issue)  fetch_pc_reg <= fetch_pc_reg + PC_STEP;
        if (accept) resp_pc_reg  <= resp_pc_reg + PC_STEP;
      end
    end
  end

  assign push_entry.pc   = resp_pc_reg;
  assign push_entry.inst = iram_rd_data_i;

  ifu_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk_i),
    .rst        (rst_i),
    .flush      (redirect),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (pop),
    .head_valid (fifo_valid),
    .head_entry (fifo_head),
    .count      (fifo_count)
  );

  assign iram_rd_req_o  = req;
  assign iram_rd_addr_o = fetch_pc_reg;
  assign inst_data_o    = inst_valid_o ? fifo_head.inst : '0;
  assign pc_data_o      = inst_valid_o ? fifo_head.pc : '0;
  assign pc_next_o      = inst_valid_o ? (fifo_head.pc + PC_STEP) : '0;

  resp_has_request: assert property (
    @(posedge clk_i) disable iff (rst_i) iram_rd_valid_i |-> (outstanding_reg != '0)
  );

endmodule
